// File: rtl/alu_divseq_pkg.sv
// alu_divseq_pkg
// Purpose: shared ALU function encoding for the bexkat1 core ALU.
//   The divider sequencer and the execute stage both use this type
//   when they drive the shared ALU.
// Contents: alufunc_t (ALU function select).
package alu_divseq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alufunc_t;

endpackage

// File: rtl/alu_divseq_if.sv
// alu_divseq_if
// Purpose: bundles the divider request/response signals and its shared-ALU
//   drive/return path into one interface.
// Signals:
//   start_i, signed_i, dividend_i, divisor_i : request (into the divider)
//   busy_o, done_o, quotient_o, remainder_o,
//   divzero_o                                : status/result (out of the divider)
//   alu_in1_o, alu_in2_o, alu_func_o         : ALU drive (out of the divider)
//   alu_out_i, alu_c_i                       : ALU result/carry (into the divider)
// Modports: slave = divider side, master = pipeline/ALU side.
interface alu_divseq_if #(
  parameter int WIDTH = 32
);
  import alu_divseq_pkg::*;

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             divzero_o;
  logic [WIDTH-1:0] alu_in1_o;
  logic [WIDTH-1:0] alu_in2_o;
  alufunc_t         alu_func_o;
  logic [WIDTH-1:0] alu_out_i;
  logic             alu_c_i;

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, alu_out_i, alu_c_i,
    output busy_o, done_o, quotient_o, remainder_o, divzero_o,
           alu_in1_o, alu_in2_o, alu_func_o
  );

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, alu_out_i, alu_c_i,
    input  busy_o, done_o, quotient_o, remainder_o, divzero_o,
           alu_in1_o, alu_in2_o, alu_func_o
  );

endinterface

// File: rtl/alu_divseq.sv
// alu_divseq
// Purpose: multi-cycle integer divider (unsigned and two's-complement signed)
//   that owns no arithmetic of its own. It sequences the shared core ALU
//   through restoring shift/subtract steps using ALU_SUB and its borrow.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : alu_divseq_if.slave (request, result, and ALU drive/return)
// Latency from the accepted start edge: unsigned WIDTH+1, signed WIDTH+5,
//   zero divisor 1 cycle.
module alu_divseq
  import alu_divseq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_divseq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEG_A = 3'd1,
    S_NEG_B = 3'd2,
    S_ITER  = 3'd3,
    S_FIX_Q = 3'd4,
    S_FIX_R = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             sg_q, sg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0] alu_in1_c;
  logic [WIDTH-1:0] alu_in2_c;
  alufunc_t         alu_func_c;
  logic [WIDTH-1:0] r_shift;
  logic             take;

  // Restoring-division step: shift the next dividend bit into R, then keep
  // R'-B whenever it does not borrow. A bit shifted out of R means R' is
  // already larger than any WIDTH-bit divisor, so the subtract is taken
  // regardless of the borrow.
  assign r_shift = {r_q[WIDTH-2:0], a_q[WIDTH-1]};
  assign take    = r_q[WIDTH-1] | ~bus.alu_c_i;

  // Next-state and ALU drive. The ALU is idle (ADD of zeros) outside the
  // negate/iterate states so the execute stage sees a benign drive.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    sg_d       = sg_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divzero_d  = divzero_q;
    alu_func_c = ALU_ADD;
    alu_in1_c  = '0;
    alu_in2_c  = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          a_d       = bus.dividend_i;
          b_d       = bus.divisor_i;
          r_d       = '0;
          cnt_d     = '0;
          sg_d      = bus.signed_i;
          sa_d      = bus.signed_i & bus.dividend_i[WIDTH-1];
          sb_d      = bus.signed_i & bus.divisor_i[WIDTH-1];
          divzero_d = 1'b0;
          if (bus.divisor_i == '0) begin
            divzero_d = 1'b1;
            quot_d    = '1;
            rem_d     = bus.dividend_i;
            state_d   = S_DONE;
          end else if (bus.signed_i) begin
            state_d = S_NEG_A;
          end else begin
            state_d = S_ITER;
          end
        end
      end
      S_NEG_A: begin
        alu_func_c = ALU_SUB;
        alu_in2_c  = a_q;
        if (sa_q) a_d = bus.alu_out_i;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        alu_func_c = ALU_SUB;
        alu_in2_c  = b_q;
        if (sb_q) b_d = bus.alu_out_i;
        state_d = S_ITER;
      end
      S_ITER: begin
        alu_func_c = ALU_SUB;
        alu_in1_c  = r_shift;
        alu_in2_c  = b_q;
        r_d        = take ? bus.alu_out_i : r_shift;
        a_d        = {a_q[WIDTH-2:0], take};
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = sg_q ? S_FIX_Q : S_DONE;
      end
      S_FIX_Q: begin
        alu_func_c = ALU_SUB;
        alu_in2_c  = a_q;
        if (sa_q ^ sb_q) a_d = bus.alu_out_i;
        state_d = S_FIX_R;
      end
      S_FIX_R: begin
        alu_func_c = ALU_SUB;
        alu_in2_c  = r_q;
        if (sa_q) r_d = bus.alu_out_i;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results are captured on the way into DONE from the computing states;
    // the zero-divisor path has already loaded them above.
    if (state_d == S_DONE && state_q != S_IDLE) begin
      quot_d = a_d;
      rem_d  = r_d;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Single state register; reset abandons any division in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      sg_q      <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      sg_q      <= sg_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.quotient_o  = quot_q;
  assign bus.remainder_o = rem_q;
  assign bus.divzero_o   = divzero_q;
  assign bus.alu_in1_o   = alu_in1_c;
  assign bus.alu_in2_o   = alu_in2_c;
  assign bus.alu_func_o  = alu_func_c;

endmodule

// File: tb/tb_alu_divseq.sv
// tb_alu_divseq
// Purpose: directed self-checking bench for alu_divseq. Provides a
//   combinational model of the shared core ALU, runs hand-computed division
//   vectors, and checks latency, results, busy/done behaviour, reset abort
//   and ignored starts.
module tb_alu_divseq;
  import alu_divseq_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   errCount;
  int   checkCount;

  alu_divseq_if #(.WIDTH(W)) bus ();

  alu_divseq #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Clock: 10 ns period; inputs change and outputs are sampled on negedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared core ALU model: SUB returns borrow (in1 < in2 unsigned) as carry.
  always_comb begin
    bus.alu_out_i = bus.alu_in1_o + bus.alu_in2_o;
    bus.alu_c_i   = 1'b0;
    case (bus.alu_func_o)
      ALU_SUB: begin
        bus.alu_out_i = bus.alu_in1_o - bus.alu_in2_o;
        bus.alu_c_i   = (bus.alu_in1_o < bus.alu_in2_o);
      end
      ALU_AND: bus.alu_out_i = bus.alu_in1_o & bus.alu_in2_o;
      ALU_OR:  bus.alu_out_i = bus.alu_in1_o | bus.alu_in2_o;
      ALU_XOR: bus.alu_out_i = bus.alu_in1_o ^ bus.alu_in2_o;
      default: begin
        bus.alu_out_i = bus.alu_in1_o + bus.alu_in2_o;
        bus.alu_c_i   = ({1'b0, bus.alu_in1_o} + {1'b0, bus.alu_in2_o}) > 33'h0_FFFF_FFFF;
      end
    endcase
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Idle-state checks: ALU drive is ADD of zeros and busy/done are low.
  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"}, 64'(bus.busy_o), 64'd0);
    checkOutput({tag, " done"}, 64'(bus.done_o), 64'd0);
    checkOutput({tag, " alu_func"}, 64'(bus.alu_func_o), 64'(ALU_ADD));
    checkOutput({tag, " alu_in1"}, 64'(bus.alu_in1_o), 64'd0);
    checkOutput({tag, " alu_in2"}, 64'(bus.alu_in2_o), 64'd0);
  endtask

  // Issue one division (accepted at "edge 0") and follow it to completion.
  // injectCycle > 0 pulses a bogus start (zero divisor, signed) during that
  // cycle, which the divider must ignore.
  task automatic applyStimulus(input string tag, input logic sgn,
                               input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                               input int expLat, input logic [W-1:0] expQ,
                               input logic [W-1:0] expR, input logic expDz,
                               input int injectCycle);
    int doneCycle;
    int busyGap;
    int doneCount;
    logic sawSub;
    doneCycle = -1;
    busyGap   = 0;
    doneCount = 0;
    sawSub    = 1'b0;

    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = sgn;
    bus.dividend_i = dvd;
    bus.divisor_i  = dvs;
    @(posedge clk);
    #1;
    bus.start_i    = 1'b0;
    bus.dividend_i = 32'h0BAD_F00D;
    bus.divisor_i  = 32'h0000_0003;

    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (doneCycle >= 0 && k == doneCycle + 1) begin
        bus.start_i = 1'b0;
        checkOutput({tag, " busy after done"}, 64'(bus.busy_o), 64'd0);
        checkOutput({tag, " done one pulse"}, 64'(bus.done_o), 64'd0);
        break;
      end
      if (bus.done_o) doneCount++;
      if (bus.done_o && doneCycle < 0) begin
        doneCycle = k;
        checkOutput({tag, " quotient"}, 64'(bus.quotient_o), 64'(expQ));
        checkOutput({tag, " remainder"}, 64'(bus.remainder_o), 64'(expR));
        checkOutput({tag, " divzero"}, 64'(bus.divzero_o), 64'(expDz));
      end
      if (!bus.busy_o) busyGap++;
      if (k == 2 && bus.alu_func_o == ALU_SUB) sawSub = 1'b1;
      bus.start_i = (k == injectCycle);
      if (k == injectCycle) begin
        bus.signed_i   = 1'b1;
        bus.dividend_i = 32'h0000_DEAD;
        bus.divisor_i  = 32'h0000_0000;
      end
    end
    bus.start_i = 1'b0;

    checkOutput({tag, " latency"}, 64'(doneCycle), 64'(expLat));
    checkOutput({tag, " busy gaps"}, 64'(busyGap), 64'd0);
    checkOutput({tag, " done pulses"}, 64'(doneCount), 64'd1);
    if (expLat > 2) checkOutput({tag, " alu sub"}, 64'(sawSub), 64'd1);

    // Results must hold while idle.
    repeat (3) @(negedge clk);
    checkOutput({tag, " quotient held"}, 64'(bus.quotient_o), 64'(expQ));
    checkOutput({tag, " remainder held"}, 64'(bus.remainder_o), 64'(expR));
    checkOutput({tag, " divzero held"}, 64'(bus.divzero_o), 64'(expDz));
    checkIdle({tag, " idle"});
  endtask

  initial begin
    int doneSeen;
    errCount       = 0;
    checkCount     = 0;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkIdle("reset");
    checkOutput("reset quotient", 64'(bus.quotient_o), 64'd0);
    checkOutput("reset remainder", 64'(bus.remainder_o), 64'd0);
    checkOutput("reset divzero", 64'(bus.divzero_o), 64'd0);

    // 100/7 = 14 r 2; bogus start mid-ITER is ignored.
    applyStimulus("u100div7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 5);
    // -7/2 truncates toward zero: -3 r -1.
    applyStimulus("s-7div2", 1'b1, 32'hFFFF_FFF9, 32'h2, 37,
                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    // Exercises the shifted-out-bit path.
    applyStimulus("uBigDiv", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 33,
                  32'h1, 32'h7FFF_FFFE, 1'b0, 0);
    // Zero divisor; bogus start during DONE is ignored.
    applyStimulus("divzero", 1'b0, 32'h1234, 32'h0, 1,
                  32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    // Signed overflow.
    applyStimulus("sOverflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 37,
                  32'h8000_0000, 32'h0, 1'b0, 0);
    // 7 / -2 = -3 r 1; bogus start during signed DONE cycle ignored.
    applyStimulus("s7divm2", 1'b1, 32'h7, 32'hFFFF_FFFE, 37,
                  32'hFFFF_FFFD, 32'h1, 1'b0, 37);
    // -100 / -7 = 14 r -2.
    applyStimulus("sm100divm7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 37,
                  32'd14, 32'hFFFF_FFFE, 1'b0, 20);

    // Reset abort during ITER cycle 10.
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd100;
    bus.divisor_i  = 32'd7;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("abort busy before reset", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdle("abort");
    checkOutput("abort quotient", 64'(bus.quotient_o), 64'd0);
    checkOutput("abort remainder", 64'(bus.remainder_o), 64'd0);
    checkOutput("abort divzero", 64'(bus.divzero_o), 64'd0);
    doneSeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) doneSeen++;
    end
    checkOutput("abort no done", 64'(doneSeen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
